// File: rtl/seg7_pkg.sv
// Shared digit codes, FSM state type and glyph lookup
// for the fixed-point seven-segment display.
package seg7_pkg;

    localparam int CODE_W = 5;
    localparam logic [CODE_W-1:0] CODE_DASH  = 5'd16;
    localparam logic [CODE_W-1:0] CODE_BLANK = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INT,
        ST_FRAC,
        ST_FMT
    } conv_state_t;

    // Active-low segment pattern, bit order g..a
    function automatic logic [6:0] seg7_glyph(
        input logic [CODE_W-1:0] code
    );
        logic [6:0] g;
        case (code)
            5'd0:    g = 7'b1000000;
            5'd1:    g = 7'b1111001;
            5'd2:    g = 7'b0100100;
            5'd3:    g = 7'b0110000;
            5'd4:    g = 7'b0011001;
            5'd5:    g = 7'b0010010;
            5'd6:    g = 7'b0000010;
            5'd7:    g = 7'b1111000;
            5'd8:    g = 7'b0000000;
            5'd9:    g = 7'b0010000;
            5'd10:   g = 7'b0001000;
            5'd11:   g = 7'b0000011;
            5'd12:   g = 7'b1000110;
            5'd13:   g = 7'b0100001;
            5'd14:   g = 7'b0000110;
            5'd15:   g = 7'b0001110;
            5'd16:   g = 7'b0111111;
            default: g = 7'h7F;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/fixpt_to_digits.sv
// Sequential signed fixed-point to decimal digit-code
// converter: double-dabble integer, x10 fraction, format.
module fixpt_to_digits
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int DATA_W      = 13,
    parameter int FRAC_BITS   = 4,
    parameter int FRAC_DIGITS = 4
) (
    input  logic                              clk_100MHz,
    input  logic                              reset,
    input  logic [DATA_W-1:0]                 data_in,
    input  logic                              data_valid,
    output logic                              ready,
    output logic [NUM_DIGITS-1:0][CODE_W-1:0] digits,
    output logic                              ovf,
    output logic                              upd
);

    localparam int INT_W      = DATA_W - FRAC_BITS;
    localparam int INT_DIGITS = NUM_DIGITS - FRAC_DIGITS;
    localparam int BCD_N      = (INT_W * 301) / 1000 + 1;
    localparam int BCD_W      = 4 * BCD_N;
    localparam int PAD_N      = (BCD_N > INT_DIGITS) ? BCD_N : INT_DIGITS;
    localparam int FD         = (FRAC_DIGITS > 0) ? FRAC_DIGITS : 1;
    localparam int PW         = FRAC_BITS + 4;

    conv_state_t state_q, state_d;

    logic [7:0]           step_q;
    logic                 sign_q;
    logic [INT_W-1:0]     int_q;
    logic [FRAC_BITS-1:0] frac_q;
    logic [BCD_W-1:0]     bcd_q;
    logic [FD-1:0][3:0]   fdig_q;

    logic [DATA_W-1:0]  mag;
    logic [BCD_W-1:0]   bcd_adj;
    logic [4*PAD_N-1:0] bcd_pad;
    logic [PW-1:0]      prod;
    logic               last_int;
    logic               last_frac;

    // Magnitude, add-3 correction and fraction product
    always_comb begin
        mag = data_in[DATA_W-1] ? (~data_in + DATA_W'(1)) : data_in;
        for (int i = 0; i < BCD_N; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            else
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
        end
        bcd_pad   = (4*PAD_N)'(bcd_q);
        prod      = PW'(frac_q) * PW'(10);
        last_int  = (step_q == 8'(INT_W - 1));
        last_frac = (step_q == 8'(FRAC_DIGITS - 1));
    end

    // State register
    always_ff @(posedge clk_100MHz) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state and handshake/strobe outputs
    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        upd     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                if (data_valid) state_d = ST_INT;
            end
            ST_INT: begin
                if (last_int)
                    state_d = (FRAC_DIGITS > 0) ? ST_FRAC : ST_FMT;
            end
            ST_FRAC: begin
                if (last_frac) state_d = ST_FMT;
            end
            ST_FMT: begin
                upd     = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Latch operand, then step the integer and fraction engines
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            step_q <= '0;
            sign_q <= 1'b0;
            int_q  <= '0;
            frac_q <= '0;
            bcd_q  <= '0;
            fdig_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (data_valid) begin
                        sign_q <= data_in[DATA_W-1];
                        int_q  <= mag[DATA_W-1:FRAC_BITS];
                        frac_q <= mag[FRAC_BITS-1:0];
                        bcd_q  <= '0;
                        step_q <= '0;
                    end
                end
                ST_INT: begin
                    bcd_q  <= {bcd_adj[BCD_W-2:0], int_q[INT_W-1]};
                    int_q  <= int_q << 1;
                    step_q <= last_int ? 8'd0 : step_q + 8'd1;
                end
                ST_FRAC: begin
                    frac_q <= prod[FRAC_BITS-1:0];
                    for (int i = FD - 1; i > 0; i--)
                        fdig_q[i] <= fdig_q[i-1];
                    fdig_q[0] <= prod[PW-1:FRAC_BITS];
                    step_q    <= last_frac ? 8'd0 : step_q + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // Blanking, sign placement and overflow detection
    always_comb begin
        int n_sig;
        int k;
        n_sig = 1;
        for (int i = 0; i < BCD_N; i++)
            if (bcd_q[4*i +: 4] != 4'd0) n_sig = i + 1;
        ovf = (n_sig + int'(sign_q)) > INT_DIGITS;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            k = i - FRAC_DIGITS;
            if (ovf)
                digits[i] = CODE_DASH;
            else if (i < FRAC_DIGITS)
                digits[i] = {1'b0, fdig_q[i % FD]};
            else if (k < n_sig)
                digits[i] = {1'b0, bcd_pad[4*k +: 4]};
            else if (k == n_sig && sign_q)
                digits[i] = CODE_DASH;
            else
                digits[i] = CODE_BLANK;
        end
    end

endmodule

// File: rtl/seg7_fixpt_display.sv
// Multiplexed seven-segment controller for signed
// fixed-point values: converter, display regs, scan.
module seg7_fixpt_display
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int DATA_W         = 13,
    parameter int FRAC_BITS      = 4,
    parameter int FRAC_DIGITS    = 4,
    parameter int REFRESH_CYCLES = 32768
) (
    input  logic                  clk_100MHz,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  data_valid,
    output logic                  ready,
    output logic [6:0]            CA,
    output logic [NUM_DIGITS-1:0] AN,
    output logic                  dp
);

    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int IW = $clog2(NUM_DIGITS);

    logic [NUM_DIGITS-1:0][CODE_W-1:0] conv_digits;
    logic                              conv_ovf;
    logic                              conv_upd;

    logic [NUM_DIGITS-1:0][CODE_W-1:0] disp_q;
    logic                              ovf_q;
    logic [RW-1:0]                     ref_q;
    logic [IW-1:0]                     idx_q;

    fixpt_to_digits #(
        .NUM_DIGITS  (NUM_DIGITS),
        .DATA_W      (DATA_W),
        .FRAC_BITS   (FRAC_BITS),
        .FRAC_DIGITS (FRAC_DIGITS)
    ) u_conv (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .ready      (ready),
        .digits     (conv_digits),
        .ovf        (conv_ovf),
        .upd        (conv_upd)
    );

    // Display registers: whole frame replaced on one edge
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            disp_q <= {NUM_DIGITS{CODE_BLANK}};
            ovf_q  <= 1'b0;
        end else if (conv_upd) begin
            disp_q <= conv_digits;
            ovf_q  <= conv_ovf;
        end
    end

    // Refresh counter and digit index, free-running
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            ref_q <= '0;
            idx_q <= '0;
        end else if (ref_q == RW'(REFRESH_CYCLES - 1)) begin
            ref_q <= '0;
            if (idx_q == IW'(NUM_DIGITS - 1)) idx_q <= '0;
            else                              idx_q <= idx_q + 1'b1;
        end else begin
            ref_q <= ref_q + 1'b1;
        end
    end

    // Registered pin drivers for the currently selected digit
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            CA <= 7'h7F;
            AN <= '1;
            dp <= 1'b1;
        end else begin
            CA <= seg7_glyph(disp_q[idx_q]);
            AN <= ~(NUM_DIGITS'(1) << idx_q);
            dp <= ~((idx_q == IW'(FRAC_DIGITS)) &&
                    (FRAC_DIGITS > 0) && !ovf_q);
        end
    end

endmodule

// File: tb/tb_seg7_fixpt_display.sv
// Bench for seg7_fixpt_display: arithmetic reference model,
// random and directed values, timing, abort and scan checks.
module tb_seg7_fixpt_display;

    localparam int RC = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [12:0] d8 = '0;
    logic [12:0] d6 = '0;
    logic        v8 = 1'b0;
    logic        v6 = 1'b0;
    logic        rdy8, rdy6;
    logic [6:0]  ca8, ca6;
    logic [7:0]  an8;
    logic [5:0]  an6;
    logic        dp8, dp6;

    always #5 clk = ~clk;

    seg7_fixpt_display #(
        .NUM_DIGITS(8), .DATA_W(13), .FRAC_BITS(4),
        .FRAC_DIGITS(4), .REFRESH_CYCLES(RC)
    ) dut (
        .clk_100MHz(clk), .reset(reset), .data_in(d8),
        .data_valid(v8), .ready(rdy8), .CA(ca8), .AN(an8), .dp(dp8)
    );

    seg7_fixpt_display #(
        .NUM_DIGITS(6), .DATA_W(13), .FRAC_BITS(4),
        .FRAC_DIGITS(4), .REFRESH_CYCLES(RC)
    ) dut6 (
        .clk_100MHz(clk), .reset(reset), .data_in(d6),
        .data_valid(v6), .ready(rdy6), .CA(ca6), .AN(an6), .dp(dp6)
    );

    int total = 0;
    int bad   = 0;

    logic [6:0] exp_ca[8];
    logic       exp_dp[8];
    logic [6:0] got_ca[8];
    logic       got_dp[8];

    function automatic logic [6:0] gl(input int c);
        case (c)
            0: return 7'b1000000;  1: return 7'b1111001;
            2: return 7'b0100100;  3: return 7'b0110000;
            4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;
            8: return 7'b0000000;  9: return 7'b0010000;
            16: return 7'b0111111;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic int p10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic int idx_of(input logic [7:0] an, input int nd);
        int r = -1;
        for (int j = 0; j < nd; j++)
            if (an == ~(8'd1 << j)) r = j;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected frame from the numeric value, digit by digit
    task automatic model(input logic [12:0] d, input int nd);
        int v, neg, mag, ip, fv, nsig, ovf, code, k;
        v    = int'($signed(d));
        neg  = (v < 0) ? 1 : 0;
        mag  = neg ? -v : v;
        ip   = mag / 16;
        fv   = (mag % 16) * 10000 / 16;
        nsig = 1;
        while (ip >= p10(nsig)) nsig++;
        ovf  = ((nsig + neg) > (nd - 4)) ? 1 : 0;
        for (int i = 0; i < 8; i++) begin
            exp_ca[i] = 7'h7F;
            exp_dp[i] = 1'b1;
        end
        for (int i = 0; i < nd; i++) begin
            k = i - 4;
            if (ovf != 0)          code = 16;
            else if (i < 4)        code = (fv / p10(i)) % 10;
            else if (k < nsig)     code = (ip / p10(k)) % 10;
            else if (k == nsig && neg != 0) code = 16;
            else                   code = 31;
            exp_ca[i] = gl(code);
            exp_dp[i] = !(i == 4 && ovf == 0);
        end
    endtask

    // Sample one full scan and compare every digit
    task automatic capture(input bit six, input string tag);
        int nd, idx;
        logic [7:0] an;
        nd = six ? 6 : 8;
        for (int i = 0; i < 8; i++) begin
            got_ca[i] = 'x;
            got_dp[i] = 1'bx;
        end
        for (int c = 0; c < nd * RC; c++) begin
            tick();
            an  = six ? {2'b11, an6} : an8;
            idx = idx_of(an, nd);
            total++;
            if (idx < 0) begin
                bad++;
                $display("FAIL %s an_onehot got=%b", tag, an);
            end else begin
                got_ca[idx] = six ? ca6 : ca8;
                got_dp[idx] = six ? dp6 : dp8;
            end
        end
        for (int i = 0; i < nd; i++) begin
            total++;
            if (got_ca[i] !== exp_ca[i] || got_dp[i] !== exp_dp[i]) begin
                bad++;
                $display("FAIL %s digit%0d ca=%b dp=%b want ca=%b dp=%b",
                         tag, i, got_ca[i], got_dp[i], exp_ca[i], exp_dp[i]);
            end
        end
    endtask

    // Wait for ready, then transfer one word
    task automatic send(input logic [12:0] d, input bit six);
        int n = 0;
        while (!(six ? rdy6 : rdy8) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL send_ready_timeout got=0 want=1");
        end
        if (six) begin d6 = d; v6 = 1'b1; end
        else     begin d8 = d; v8 = 1'b1; end
        tick();
        v6 = 1'b0;
        v8 = 1'b0;
    endtask

    task automatic run_value(input logic [12:0] d, input bit six);
        string tag;
        send(d, six);
        for (int i = 0; i < 15; i++) tick();
        model(d, six ? 6 : 8);
        tag = $sformatf("val_%h_n%0d", d, six ? 6 : 8);
        capture(six, tag);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++;
        if (rdy8 !== 1'b1 || ca8 !== 7'h7F || an8 !== 8'hFF || dp8 !== 1'b1) begin
            bad++;
            $display("FAIL reset8 rdy=%b ca=%h an=%h dp=%b want 1 7f ff 1",
                     rdy8, ca8, an8, dp8);
        end
        total++;
        if (rdy6 !== 1'b1 || ca6 !== 7'h7F || an6 !== 6'h3F || dp6 !== 1'b1) begin
            bad++;
            $display("FAIL reset6 rdy=%b ca=%h an=%h dp=%b want 1 7f 3f 1",
                     rdy6, ca6, an6, dp6);
        end
        reset = 1'b0;
    endtask

    task automatic test_scan();
        logic [7:0] ea;
        for (int k = 1; k <= 36; k++) begin
            tick();
            ea = ~(8'd1 << (((k - 1) / RC) % 8));
            total++;
            if (an8 !== ea || ca8 !== 7'h7F || dp8 !== (ea != 8'hEF)) begin
                bad++;
                $display("FAIL scan_c%0d an=%b ca=%h dp=%b want an=%b ca=7f dp=%b",
                         k, an8, ca8, dp8, ea, (ea != 8'hEF));
            end
        end
    endtask

    task automatic test_latency();
        int idx;
        send(13'h1000, 1'b0);
        for (int k = 1; k <= 13; k++) begin
            tick();
            total++;
            if (rdy8 !== 1'b0) begin
                bad++;
                $display("FAIL lat_ready_T+%0d got=%b want=0", k, rdy8);
            end
        end
        tick();
        total++;
        if (rdy8 !== 1'b1 || ca8 !== 7'h7F) begin
            bad++;
            $display("FAIL lat_T+14 rdy=%b ca=%h want 1 7f", rdy8, ca8);
        end
        tick();
        model(13'h1000, 8);
        idx = idx_of(an8, 8);
        total++;
        if (idx < 0 || ca8 !== exp_ca[idx < 0 ? 0 : idx]) begin
            bad++;
            $display("FAIL lat_T+15 idx=%0d ca=%h", idx, ca8);
        end
        capture(1'b0, "neg256");
    endtask

    task automatic test_values();
        logic [12:0] fixed[4] = '{13'h0190, 13'h1FFF, 13'h0FFF, 13'h0000};
        foreach (fixed[i]) run_value(fixed[i], 1'b0);
        for (int i = 0; i < 8; i++)
            run_value(13'($urandom_range(0, 8191)), 1'b0);
    endtask

    task automatic test_overflow();
        run_value(13'h0640, 1'b1);
        run_value(13'h1F60, 1'b1);
        run_value(13'h0190, 1'b1);
        run_value(13'h1F70, 1'b1);
        for (int i = 0; i < 6; i++)
            run_value(13'($urandom_range(0, 8191)), 1'b1);
    endtask

    task automatic test_back_to_back();
        send(13'h0123, 1'b0);
        for (int k = 1; k <= 13; k++) begin
            if (k == 5) begin d8 = 13'h0777; v8 = 1'b1; end
            tick();
            v8 = 1'b0;
            total++;
            if (rdy8 !== 1'b0) begin
                bad++;
                $display("FAIL b2b_ready_T+%0d got=%b want=0", k, rdy8);
            end
        end
        tick();
        total++;
        if (rdy8 !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ready_T+14 got=%b want=1", rdy8);
        end
        tick();
        model(13'h0123, 8);
        capture(1'b0, "b2b_first");
    endtask

    task automatic test_reset_abort();
        run_value(13'h0FFF, 1'b0);
        send(13'h1000, 1'b0);
        for (int k = 1; k <= 5; k++) tick();
        reset = 1'b1;
        tick();
        total++;
        if (rdy8 !== 1'b1 || an8 !== 8'hFF || ca8 !== 7'h7F || dp8 !== 1'b1) begin
            bad++;
            $display("FAIL abort_edge rdy=%b an=%h ca=%h dp=%b want 1 ff 7f 1",
                     rdy8, an8, ca8, dp8);
        end
        reset = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        for (int i = 0; i < 8; i++) begin
            exp_ca[i] = 7'h7F;
            exp_dp[i] = (i != 4);
        end
        capture(1'b0, "abort_blank");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_scan();
        test_latency();
        test_values();
        test_overflow();
        test_back_to_back();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_fixpt_display.md
# seg7_fixpt_display

Parametrised, multiplexed seven-segment controller for signed fixed-point sensor values. It accepts a two's-complement word under a valid/ready handshake and converts it sequentially into decimal digits: double-dabble for the integer part, multiply-by-10 for the fraction. It then applies leading-zero blanking and sign placement, and scans the result across `NUM_DIGITS` common-anode digits. It sits between the temperature front end (I2C master or switch input) and the board display pins.

## Interface
- `NUM_DIGITS`, 8: number of physical digits (4..8).
- `DATA_W`, 13: input word width, two's complement.
- `FRAC_BITS`, 4: binary fraction bits in `data_in`.
- `FRAC_DIGITS`, 4: decimal fraction digits shown (0..`NUM_DIGITS`-2).
- `REFRESH_CYCLES`, 32768: clock cycles each digit is lit.
- `clk_100MHz` in, 1: system clock.
- `reset` in, 1: one clock; reset is synchronous and active-high.
- `data_in` in, `DATA_W`: value = `data_in` / 2^`FRAC_BITS`.
- `data_valid` in, 1: `data_in` is offered.
- `ready` out, 1: block can accept; a transfer occurs when `data_valid` && `ready`.
- `CA` out, 7: segments g..a, active-low.
- `AN` out, `NUM_DIGITS`: digit enables, active-low one-hot; bit 0 is the rightmost digit.
- `dp` out, 1: decimal point, active-low.

## Operation
- Derived widths:
  - INT_W = `DATA_W` - `FRAC_BITS`.
  - INT_DIGITS = `NUM_DIGITS` - `FRAC_DIGITS`.
- Digit code is 5 bits: 0..15 are hex glyphs, 16 is dash, 31 is blank. Any other code displays blank.
- FSM: IDLE → INT → FRAC → FMT → IDLE.
  - **IDLE**: `ready`=1. On transfer, latch sign = MSB and magnitude = |`data_in`| as `DATA_W`-bit unsigned (most negative value is exact). Go to INT.
  - **INT**: INT_W cycles of double-dabble on magnitude[`DATA_W`-1:`FRAC_BITS`]. Each cycle adds 3 to every BCD nibble ≥5, then shifts left 1.
  - **FRAC**: `FRAC_DIGITS` cycles. p = frac×10 (`FRAC_BITS`+4 bits); digit = p[`FRAC_BITS`+3:`FRAC_BITS`]; frac ← p[`FRAC_BITS`-1:0]. The result is truncated, not rounded. With 4 fraction bits and 4 fraction digits it is exact. If `FRAC_DIGITS`=0, FRAC is skipped.
  - **FMT**: one cycle, then go to IDLE.
    - Blank integer digits above the most significant nonzero digit. The units digit is always shown.
    - If negative, place a dash in the position immediately left of the leftmost shown digit.
    - Overflow: digits needed (plus 1 if negative) > INT_DIGITS. On overflow every digit shows a dash and `dp` stays high.
    - Write all display registers in the same edge, so there is no tearing.
- `data_valid` while `ready`=0 is ignored. There is no queueing.
- Scan:
  - The refresh counter counts 0..`REFRESH_CYCLES`-1.
  - On wrap, the digit index increments, wrapping from `NUM_DIGITS`-1 to 0.
  - `AN` = ~(1 << index). `CA` = glyph(display[index]).
  - `dp`=0 only when index == `FRAC_DIGITS`, `FRAC_DIGITS`>0, and not in overflow.
- Scanning runs continuously and is independent of conversion.

## Timing
- Reset values:
  - `ready`=1, `CA`=7'h7F, `AN`=all ones, `dp`=1.
  - Display registers all blank, FSM in IDLE.
  - Refresh counter and digit index are 0.
- Transfer at edge T:
  - `ready`=0 from T+1.
  - Display registers update at edge T+INT_W+`FRAC_DIGITS`+1.
  - `ready`=1 on the same edge as the display update. With defaults this is T+14.
- `CA`/`AN`/`dp` are registered: one cycle after the index and display registers.
- After reset release, the first `AN` low (digit 0) appears at cycle 1.
- Reset during INT/FRAC/FMT aborts the conversion. No partial result is displayed and the display reverts to blank.
- Back-to-back transfer: a new `data_valid` is accepted on the first edge at which `ready`=1 (minimum interval INT_W+`FRAC_DIGITS`+2 cycles).

## Structure
- `seg7_pkg`:
  - Constants: digit code widths, CODE_DASH=16, CODE_BLANK=31.
  - Function `seg7_glyph(code)` returning the active-low `CA` pattern (0..F, dash=7'b0111111, else 7'h7F).
  - Typedef for the FSM state enum.
- Sub-module `fixpt_to_digits`: contains the handshake, FSM, double-dabble, fraction stepping and FMT. Its output is the digit-code array plus an update strobe.
- Top level: instantiates `fixpt_to_digits`, the display registers and the scan counter/mux.

## Test plan
- Defaults, `REFRESH_CYCLES`=4, `data_in`=13'h0190 (25.0) → after 14 cycles digits read blank,blank,2,5.,0,0,0,0; `dp` low only on `AN`=8'b11101111; `AN` steps every 4 cycles and wraps from bit 7 to bit 0.
- `data_in`=13'h1FFF (-0.0625) → blank,blank,-,0.,0,6,2,5.
- `data_in`=13'h1000 (-256) → -,2,5,6.,0,0,0,0. `data_in`=13'h0FFF → blank,2,5,5.,9,3,7,5.
- `NUM_DIGITS`=6, `FRAC_DIGITS`=4, `data_in`=13'h0640 (100.0) → all six digits dash, `dp` high. 13'h1F60 (-10.0) → also overflow.
- Pulse `data_valid` at T, then again at T+5 with a different value → second value ignored, display shows the first. `ready` is low for exactly 13 cycles.
- Assert `reset` at T+6 mid-conversion → at the next edge `ready`=1, `AN`=all ones, `CA`=7'h7F; display stays blank, no digits shown.
